cache_port_arbiter: RTL and testbench

Parametrised, registered arbiter for one read/write port of the data cache memory. It grants the port to one of `CHANNELS` requesters (load controller, store controller, invalidation/snoop, prefetch, ...) and supports round-robin or fixed-priority policy, multi-cycle ownership with a fairness hold limit, and zero-bubble hand-over. It also registers the owner and tag of every read, so that the hit-check result one cycle later is attributed to the channel and address that issued it. It sits between the per-unit cache controllers and the cache memory port, replacing the fixed store-over-load combinational mux.

---
 rtl/cache_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Registered arbiter for one read/write port of the data cache memory.
//   Grants the port to one of CHANNELS requesters using round-robin or
//   fixed-priority arbitration. An owner may hold the port for several
//   cycles, but after MAX_HOLD consecutive cycles it is revoked if another
//   channel is waiting. When the owner releases the port, a waiting channel
//   takes over on the same edge. The issuer and tag of every read are
//   registered so the hit check one cycle later can be attributed to them.
//
// Ports
//   clk_i, rst_n_i   clock (rising edge), asynchronous active-low reset
//   ch_request_i     per-channel request level, held until done
//   ch_write_i       per-channel write strobe (only the owner's is used)
//   ch_read_i        per-channel read strobe (only the owner's is used)
//   ch_cmd_i         per-channel command words, channel k at [k*CMD_WIDTH +: CMD_WIDTH]
//   ch_tag_i         per-channel lookup tags, channel k at [k*TAG_WIDTH +: TAG_WIDTH]
//   grant_o          one-hot registered grant; all zero means the port is free
//   port_write_o     write strobe to the memory port
//   port_read_o      read strobe to the memory port
//   port_cmd_o       command word to the memory port
//   resp_valid_o     a read was issued in the previous cycle
//   resp_owner_o     one-hot issuer of that read
//   resp_tag_o       tag of that read
module cache_port_arbiter #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned CMD_WIDTH        = 64,
  parameter int unsigned TAG_WIDTH        = 20,
  parameter int unsigned PRIORITY_MODE    = 0,
  parameter int unsigned PRIORITY_CHANNEL = 0,
  parameter int unsigned MAX_HOLD         = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [CHANNELS-1:0]            ch_request_i,
  input  logic [CHANNELS-1:0]            ch_write_i,
  input  logic [CHANNELS-1:0]            ch_read_i,
  input  logic [CHANNELS*CMD_WIDTH-1:0]  ch_cmd_i,
  input  logic [CHANNELS*TAG_WIDTH-1:0]  ch_tag_i,
  output logic [CHANNELS-1:0]            grant_o,
  output logic                           port_write_o,
  output logic                           port_read_o,
  output logic [CMD_WIDTH-1:0]           port_cmd_o,
  output logic                           resp_valid_o,
  output logic [CHANNELS-1:0]            resp_owner_o,
  output logic [TAG_WIDTH-1:0]           resp_tag_o
);

  localparam int unsigned PTR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [CHANNELS-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [CHANNELS-1:0]  resp_owner_q, resp_owner_d;
  logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;

  logic                 owner_req;
  logic                 others_pend;
  logic                 keep;
  logic [CHANNELS-1:0]  others;
  logic [CHANNELS-1:0]  win;
  logic [PTR_W-1:0]     win_next_ptr;
  logic                 found;
  int unsigned          ptr_u;
  logic [TAG_WIDTH-1:0] sel_tag;

  // Arbitration. The candidate set always excludes the current owner: when
  // we get here either the owner has dropped its request (so excluding it
  // changes nothing) or it is being revoked because someone else waits.
  always_comb begin
    owner_req    = |(grant_q & ch_request_i);
    others       = ch_request_i & ~grant_q;
    others_pend  = |others;
    keep         = owner_req && ((hold_cnt_q < HOLD_W'(MAX_HOLD)) || !others_pend);
    win          = '0;
    win_next_ptr = '0;
    found        = 1'b0;
    ptr_u        = 32'(rr_ptr_q);

    if (PRIORITY_MODE == 1 && others[PRIORITY_CHANNEL]) begin
      win[PRIORITY_CHANNEL] = 1'b1;
      found                 = 1'b1;
      win_next_ptr          = (PRIORITY_CHANNEL + 1 == CHANNELS) ? '0 : PTR_W'(PRIORITY_CHANNEL + 1);
    end

    // Upward modulo search from rr_ptr: first the channels at or above the
    // pointer, then the ones below it.
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (!found && j >= ptr_u && others[j]) begin
        win[j]       = 1'b1;
        found        = 1'b1;
        win_next_ptr = (j + 1 == CHANNELS) ? '0 : PTR_W'(j + 1);
      end
    end
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (!found && j < ptr_u && others[j]) begin
        win[j]       = 1'b1;
        found        = 1'b1;
        win_next_ptr = (j + 1 == CHANNELS) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  always_comb begin
    grant_d    = '0;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = '0;
    if (keep) begin
      grant_d    = grant_q;
      hold_cnt_d = (hold_cnt_q < HOLD_W'(MAX_HOLD)) ? hold_cnt_q + HOLD_W'(1) : hold_cnt_q;
    end else if (found) begin
      grant_d    = win;
      rr_ptr_d   = win_next_ptr;
      hold_cnt_d = HOLD_W'(1);
    end
  end

  // Port datapath: the grant is one-hot, so OR-ing the masked channel
  // fields selects the owner and yields zero when the port is free.
  always_comb begin
    port_cmd_o   = '0;
    port_write_o = 1'b0;
    port_read_o  = 1'b0;
    sel_tag      = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (grant_q[j]) begin
        port_cmd_o   = port_cmd_o | ch_cmd_i[j*CMD_WIDTH +: CMD_WIDTH];
        port_write_o = port_write_o | ch_write_i[j];
        port_read_o  = port_read_o | ch_read_i[j];
        sel_tag      = sel_tag | ch_tag_i[j*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    resp_valid_d = port_read_o;
    resp_owner_d = port_read_o ? grant_q : resp_owner_q;
    resp_tag_d   = port_read_o ? sel_tag : resp_tag_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= '0;
      resp_tag_q   <= '0;
    end else begin
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  assign grant_o      = grant_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_owner_o = resp_owner_q;
  assign resp_tag_o   = resp_tag_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter. Two instances share clock and reset:
//   u_a: 4 channels, round-robin, MAX_HOLD=4
//   u_b: 2 channels, priority mode favouring channel 1, MAX_HOLD=16
// Inputs are driven on the falling edge; outputs are checked 1 ns later.
module tb_cache_port_arbiter;

  logic clk;
  logic rst_n;

  logic [3:0]   a_req, a_wr, a_rd;
  logic [255:0] a_cmd;
  logic [79:0]  a_tag;
  logic [3:0]   a_grant;
  logic         a_pwr, a_prd;
  logic [63:0]  a_pcmd;
  logic         a_rvalid;
  logic [3:0]   a_rowner;
  logic [19:0]  a_rtag;

  logic [1:0]   b_req, b_wr, b_rd;
  logic [127:0] b_cmd;
  logic [39:0]  b_tag;
  logic [1:0]   b_grant;
  logic         b_pwr, b_prd;
  logic [63:0]  b_pcmd;
  logic         b_rvalid;
  logic [1:0]   b_rowner;
  logic [19:0]  b_rtag;

  int n_assert;
  int n_fail;
  logic chk_en;

  cache_port_arbiter #(
    .CHANNELS(4), .CMD_WIDTH(64), .TAG_WIDTH(20),
    .PRIORITY_MODE(0), .PRIORITY_CHANNEL(0), .MAX_HOLD(4)
  ) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .ch_request_i(a_req), .ch_write_i(a_wr), .ch_read_i(a_rd),
    .ch_cmd_i(a_cmd), .ch_tag_i(a_tag),
    .grant_o(a_grant), .port_write_o(a_pwr), .port_read_o(a_prd),
    .port_cmd_o(a_pcmd), .resp_valid_o(a_rvalid),
    .resp_owner_o(a_rowner), .resp_tag_o(a_rtag)
  );

  cache_port_arbiter #(
    .CHANNELS(2), .CMD_WIDTH(64), .TAG_WIDTH(20),
    .PRIORITY_MODE(1), .PRIORITY_CHANNEL(1), .MAX_HOLD(16)
  ) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .ch_request_i(b_req), .ch_write_i(b_wr), .ch_read_i(b_rd),
    .ch_cmd_i(b_cmd), .ch_tag_i(b_tag),
    .grant_o(b_grant), .port_write_o(b_pwr), .port_read_o(b_prd),
    .port_cmd_o(b_pcmd), .resp_valid_o(b_rvalid),
    .resp_owner_o(b_rowner), .resp_tag_o(b_rtag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Requesters must only strobe while granted.
  always @(negedge clk) begin
    #3;
    if (chk_en && rst_n) begin
      n_assert++;
      assert ((((a_wr | a_rd) & ~a_grant) === 4'b0) && (((b_wr | b_rd) & ~b_grant) === 2'b0)) else begin
        n_fail++;
        $error("FAIL protocol_strobe: observed a=%b b=%b, expected 0", (a_wr | a_rd) & ~a_grant, (b_wr | b_rd) & ~b_grant);
      end
    end
  end

  // One cycle of u_a: drive request/strobes, then check grant and the
  // command that the expected owner (cmd = 0x1000+k) puts on the port.
  task automatic a_cyc(input logic [3:0] req, input logic [3:0] rd, input logic [3:0] wr,
                       input logic [3:0] exp_grant, input string tag);
    logic [63:0] exp_cmd;
    @(negedge clk);
    a_req = req;
    a_rd  = rd;
    a_wr  = wr;
    #1;
    exp_cmd = '0;
    for (int k = 0; k < 4; k++)
      if (exp_grant == (4'b0001 << k)) exp_cmd = 64'h1000 + 64'(k);
    chk({tag, "_grant"}, 64'(a_grant), 64'(exp_grant));
    chk({tag, "_cmd"}, a_pcmd, exp_cmd);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; chk_en = 1'b1;
    n_assert = 0; n_fail = 0;
    a_req = '0; a_wr = '0; a_rd = '0; b_req = '0; b_wr = '0; b_rd = '0;
    for (int k = 0; k < 4; k++) begin
      a_cmd[k*64 +: 64] = 64'h1000 + 64'(k);
      a_tag[k*20 +: 20] = 20'h0A0 + 20'(k);
    end
    b_cmd = {64'hABCD, 64'h1111};
    b_tag = {20'h5, 20'h7};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_grant", 64'(a_grant), 64'h0);
    chk("rst_a_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_a_pread", 64'(a_prd), 64'h0);
    chk("rst_b_grant", 64'(b_grant), 64'h0);
    chk("rst_b_rtag", 64'(b_rtag), 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single read on u_b: ch1 requests in cycle 0
    @(negedge clk); b_req = 2'b10; #1;
    chk("b_c0_grant", 64'(b_grant), 64'h0);
    @(negedge clk); b_rd = 2'b10; #1;
    chk("b_c1_grant", 64'(b_grant), 64'h2);
    chk("b_c1_cmd", b_pcmd, 64'hABCD);
    chk("b_c1_pread", 64'(b_prd), 64'h1);
    chk("b_c1_rvalid", 64'(b_rvalid), 64'h0);
    @(negedge clk); b_rd = 2'b00; b_req = 2'b00; #1;
    chk("b_c2_rvalid", 64'(b_rvalid), 64'h1);
    chk("b_c2_rowner", 64'(b_rowner), 64'h2);
    chk("b_c2_rtag", 64'(b_rtag), 64'h5);
    chk("b_c2_pread", 64'(b_prd), 64'h0);
    // Priority from idle: both request, ch1 wins although rr_ptr is 0
    @(negedge clk); b_req = 2'b11; #1;
    chk("b_c3_grant", 64'(b_grant), 64'h0);
    chk("b_c3_rvalid", 64'(b_rvalid), 64'h0);
    chk("b_c3_rtag_hold", 64'(b_rtag), 64'h5);
    @(negedge clk); b_req = 2'b01; #1;
    chk("b_prio_grant", 64'(b_grant), 64'h2);
    // ch1 drops, ch0 takes over with no bubble; ch1 then re-requests and
    // strobes write while not owner
    @(negedge clk); chk_en = 1'b0; b_req = 2'b11; b_wr = 2'b10; #1;
    chk("b_handover_grant", 64'(b_grant), 64'h1);
    chk("b_nonowner_pwr", 64'(b_pwr), 64'h0);
    chk("b_nonowner_cmd", b_pcmd, 64'h1111);
    @(negedge clk); b_req = 2'b10; b_wr = 2'b11; #1;
    chk("b_noprempt_grant", 64'(b_grant), 64'h1);
    chk("b_owner_pwr", 64'(b_pwr), 64'h1);
    @(negedge clk); b_wr = 2'b00; chk_en = 1'b1; b_req = 2'b00; #1;
    chk("b_c7_grant", 64'(b_grant), 64'h2);
    @(negedge clk); #1;
    chk("b_c8_grant", 64'(b_grant), 64'h0);

    // Round-robin hand-over on u_a, one owned cycle each
    a_cyc(4'b1111, 4'b0000, 4'b0000, 4'b0000, "rr0");
    a_cyc(4'b1110, 4'b0000, 4'b0000, 4'b0001, "rr1");
    a_cyc(4'b1100, 4'b0010, 4'b0000, 4'b0010, "rr2");
    chk("rr2_pread", 64'(a_prd), 64'h1);
    a_cyc(4'b1000, 4'b0000, 4'b0000, 4'b0100, "rr3");
    chk("rr3_rvalid", 64'(a_rvalid), 64'h1);
    chk("rr3_rowner", 64'(a_rowner), 64'h2);
    chk("rr3_rtag", 64'(a_rtag), 64'h0A1);
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b1000, "rr4");
    a_cyc(4'b0000, 4'b0000, 4'b0000, 4'b0001, "rr5");

    // Hold limit: ch0 requests forever, ch1 from cycle 2
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0000, "h0");
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001, "h1");
    a_cyc(4'b0011, 4'b0000, 4'b0000, 4'b0001, "h2");
    a_cyc(4'b0011, 4'b0000, 4'b0000, 4'b0001, "h3");
    a_cyc(4'b0011, 4'b0000, 4'b0001, 4'b0001, "h4");
    chk("h4_last_write", 64'(a_pwr), 64'h1);
    a_cyc(4'b0011, 4'b0000, 4'b0000, 4'b0010, "h5");
    chk("h5_pwr", 64'(a_pwr), 64'h0);
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0010, "h6");
    // ch0 alone beyond the hold limit keeps the port
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001, "h7");
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001, "h8");
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001, "h9");
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001, "h10");
    a_cyc(4'b0001, 4'b0000, 4'b0000, 4'b0001, "h11");
    a_cyc(4'b0101, 4'b0000, 4'b0000, 4'b0001, "h12");
    a_cyc(4'b0100, 4'b0100, 4'b0000, 4'b0100, "h13");
    chk("h13_pread", 64'(a_prd), 64'h1);

    // Reset mid-ownership while ch2 reads
    a_cyc(4'b0100, 4'b0100, 4'b0000, 4'b0100, "h14");
    chk("h14_rvalid", 64'(a_rvalid), 64'h1);
    chk("h14_rowner", 64'(a_rowner), 64'h4);
    chk("h14_rtag", 64'(a_rtag), 64'h0A2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(a_grant), 64'h0);
    chk("mid_rst_pread", 64'(a_prd), 64'h0);
    chk("mid_rst_rvalid", 64'(a_rvalid), 64'h0);
    chk("mid_rst_rowner", 64'(a_rowner), 64'h0);
    chk("mid_rst_rtag", 64'(a_rtag), 64'h0);
    @(negedge clk); a_rd = 4'b0000; rst_n = 1'b1; #1;
    chk("rel_grant", 64'(a_grant), 64'h0);
    a_cyc(4'b0100, 4'b0000, 4'b0000, 4'b0100, "regrant");
    a_cyc(4'b0000, 4'b0000, 4'b0000, 4'b0100, "drop");
    a_cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
